// File: rtl/fetch_stage.sv
// Instruction fetch stage: PC, req/ack instruction memory read, instruction register with stall/redirect.
// Optional terminal halt on HALT_WORD is enabled by defining FETCH_HALT_EN.
module fetch_stage #(
  parameter logic [15:0] RESET_PC  = 16'h0000,
  parameter logic [15:0] HALT_WORD = 16'hFFFF
) (
  input  logic        i_clk,
  input  logic        i_rst,
  output logic [15:0] o_memAddr,
  output logic        o_memReq,
  input  logic        i_memAck,
  input  logic [15:0] i_memData,
  input  logic        i_stall,
  input  logic        i_jmpEn,
  input  logic [15:0] i_jmpAddr,
  output logic        o_instrValid,
  output logic [15:0] o_instr,
  output logic [3:0]  o_instrOpcode,
  output logic [7:0]  o_instrImm,
  output logic [15:0] o_pc,
  output logic        o_halted
);

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    VALID = 2'd1,
    HALT  = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [15:0] pc_q, pc_d;
  logic [15:0] instr_q, instr_d;
  logic [15:0] instr_pc_q, instr_pc_d;
  logic        halted_q, halted_d;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q    <= FETCH;
      pc_q       <= RESET_PC;
      instr_q    <= 16'h0000;
      instr_pc_q <= 16'h0000;
      halted_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      instr_q    <= instr_d;
      instr_pc_q <= instr_pc_d;
      halted_q   <= halted_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    instr_d    = instr_q;
    instr_pc_d = instr_pc_q;
    halted_d   = halted_q;
    case (state_q)
      FETCH: begin
        // A redirect wins over a same-cycle ack; the acked word is dropped.
        if (i_jmpEn) begin
          pc_d = i_jmpAddr;
        end else if (i_memAck) begin
          instr_d    = i_memData;
          instr_pc_d = pc_q;
          pc_d       = pc_q + 16'd1;
          state_d    = VALID;
`ifdef FETCH_HALT_EN
          halted_d   = (i_memData == HALT_WORD);
`else
          halted_d   = 1'b0;
`endif
        end
      end
      VALID: begin
        // Once a halt word is latched, redirects no longer apply.
        if (i_jmpEn && !halted_q) begin
          pc_d    = i_jmpAddr;
          state_d = FETCH;
        end else if (!i_stall) begin
          state_d = halted_q ? HALT : FETCH;
        end
      end
      HALT: begin
        state_d = HALT;
      end
      default: begin
        state_d = FETCH;
      end
    endcase
  end

  assign o_memReq      = (state_q == FETCH);
  assign o_memAddr     = pc_q;
  assign o_instrValid  = (state_q == VALID);
  assign o_instr       = instr_q;
  assign o_instrOpcode = instr_q[15:12];
  assign o_instrImm    = instr_q[7:0];
  assign o_pc          = instr_pc_q;
  assign o_halted      = halted_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: directed test-plan steps followed by a randomized run
// checked against a transaction-level reference model of the fetch protocol.
module tb_fetch_stage;

  localparam logic [15:0] RESET_PC  = 16'h0000;
  localparam logic [15:0] HALT_WORD = 16'hFFFF;
`ifdef FETCH_HALT_EN
  localparam bit HALT_EN = 1'b1;
`else
  localparam bit HALT_EN = 1'b0;
`endif

  logic        i_clk = 1'b0;
  logic        i_rst = 1'b0;
  logic [15:0] o_memAddr;
  logic        o_memReq;
  logic        i_memAck = 1'b0;
  logic [15:0] i_memData = 16'h0000;
  logic        i_stall = 1'b0;
  logic        i_jmpEn = 1'b0;
  logic [15:0] i_jmpAddr = 16'h0000;
  logic        o_instrValid;
  logic [15:0] o_instr;
  logic [3:0]  o_instrOpcode;
  logic [7:0]  o_instrImm;
  logic [15:0] o_pc;
  logic        o_halted;

  int testsRun = 0;
  int testsFailed = 0;

  // Reference model: what the stage holds, in protocol terms.
  int  mPc;
  int  mInstr;
  int  mInstrPc;
  bit  mHaveInstr;
  bit  mHaltSeen;
  bit  mStopped;

  fetch_stage #(
    .RESET_PC (RESET_PC),
    .HALT_WORD(HALT_WORD)
  ) dut (
    .i_clk        (i_clk),
    .i_rst        (i_rst),
    .o_memAddr    (o_memAddr),
    .o_memReq     (o_memReq),
    .i_memAck     (i_memAck),
    .i_memData    (i_memData),
    .i_stall      (i_stall),
    .i_jmpEn      (i_jmpEn),
    .i_jmpAddr    (i_jmpAddr),
    .o_instrValid (o_instrValid),
    .o_instr      (o_instr),
    .o_instrOpcode(o_instrOpcode),
    .o_instrImm   (o_instrImm),
    .o_pc         (o_pc),
    .o_halted     (o_halted)
  );

  always #5 i_clk = ~i_clk;

  task automatic chk(input string tag, input logic [15:0] observed, input logic [15:0] expected);
    testsRun++;
    assert (observed === expected)
    else begin
      testsFailed++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  // Advance the model by one clock using the inputs the bench drove for that cycle.
  task automatic modelStep(input bit rst, input bit ack, input int data, input bit stall,
                           input bit jmp, input int jaddr);
    if (rst) begin
      mPc = RESET_PC; mInstr = 0; mInstrPc = 0;
      mHaveInstr = 0; mHaltSeen = 0; mStopped = 0;
    end else if (mStopped) begin
      // terminal: nothing moves until reset
    end else if (jmp && !mHaltSeen) begin
      mPc = jaddr % 65536;
      mHaveInstr = 0;
    end else if (!mHaveInstr) begin
      if (ack) begin
        mInstr = data; mInstrPc = mPc;
        mPc = (mPc + 1) % 65536;
        mHaveInstr = 1;
        mHaltSeen = HALT_EN && (data == 65535);
      end
    end else if (!stall) begin
      mHaveInstr = 0;
      if (mHaltSeen) mStopped = 1;
    end
  endtask

  task automatic checkOutput(input string tag);
    bit expReq;
    expReq = !mHaveInstr && !mStopped;
    chk({tag, ".req"}, {15'd0, o_memReq}, {15'd0, expReq});
    if (expReq) chk({tag, ".addr"}, o_memAddr, 16'(mPc));
    chk({tag, ".valid"}, {15'd0, o_instrValid}, {15'd0, mHaveInstr});
    chk({tag, ".instr"}, o_instr, 16'(mInstr));
    chk({tag, ".opcode"}, {12'd0, o_instrOpcode}, 16'(mInstr / 4096));
    chk({tag, ".imm"}, {8'd0, o_instrImm}, 16'(mInstr % 256));
    chk({tag, ".pc"}, o_pc, 16'(mInstrPc));
    chk({tag, ".halted"}, {15'd0, o_halted}, {15'd0, mHaltSeen});
  endtask

  task automatic applyStimulus(input string tag, input bit rst, input bit ack, input logic [15:0] data,
                               input bit stall, input bit jmp, input logic [15:0] jaddr);
    i_rst = rst; i_memAck = ack; i_memData = data;
    i_stall = stall; i_jmpEn = jmp; i_jmpAddr = jaddr;
    @(posedge i_clk);
    modelStep(rst, ack, int'(data), stall, jmp, int'(jaddr));
    #1;
    checkOutput(tag);
  endtask

  initial begin
    logic [15:0] firstAddr;
    logic [15:0] rdata;
    mPc = 0; mInstr = 0; mInstrPc = 0; mHaveInstr = 0; mHaltSeen = 0; mStopped = 0;

    // Reset, then zero-wait fetch of 0x1234 from address 0.
    applyStimulus("reset", 1, 1, 16'h5555, 0, 0, 16'h0);
    chk("reset.addrConst", o_memAddr, RESET_PC);
    applyStimulus("ack0", 0, 1, 16'h1234, 0, 0, 16'h0);
    chk("ack0.instrConst", o_instr, 16'h1234);
    chk("ack0.opConst", {12'd0, o_instrOpcode}, 16'h0001);
    chk("ack0.immConst", {8'd0, o_instrImm}, 16'h0034);
    applyStimulus("consume0", 0, 0, 16'h0, 0, 0, 16'h0);
    chk("consume0.nextAddr", o_memAddr, 16'h0001);

    // Three wait cycles: address must hold steady.
    firstAddr = o_memAddr;
    for (int i = 0; i < 3; i++) begin
      applyStimulus("wait", 0, 0, 16'hDEAD, 0, 0, 16'h0);
      chk("wait.stable", o_memAddr, firstAddr);
    end
    applyStimulus("ackLate", 0, 1, 16'h7A5C, 0, 0, 16'h0);

    // Stall held for 5 cycles, then release.
    for (int i = 0; i < 5; i++) applyStimulus("stall", 0, 0, 16'h0, 1, 0, 16'h0);
    chk("stall.pcConst", o_pc, 16'h0001);
    applyStimulus("unstall", 0, 0, 16'h0, 0, 0, 16'h0);
    chk("unstall.addrConst", o_memAddr, 16'h0002);

    // Jump in the same cycle as an ack carrying 0xABCD.
    applyStimulus("jmpAck", 0, 1, 16'hABCD, 0, 1, 16'h0100);
    chk("jmpAck.addrConst", o_memAddr, 16'h0100);

    // Jump during VALID beats stall.
    applyStimulus("ack100", 0, 1, 16'h3C01, 0, 0, 16'h0);
    applyStimulus("jmpStall", 0, 0, 16'h0, 1, 1, 16'h0200);

    // Wrap-around: jump to 0xFFFF, fetch, next request is 0x0000.
    applyStimulus("jmpTop", 0, 0, 16'h0, 0, 1, 16'hFFFF);
    applyStimulus("ackTop", 0, 1, 16'h2222, 0, 0, 16'h0);
    chk("ackTop.pcConst", o_pc, 16'hFFFF);
    applyStimulus("consumeTop", 0, 0, 16'h0, 0, 0, 16'h0);
    chk("consumeTop.wrap", o_memAddr, 16'h0000);

    // Reset mid-transaction discards the pending ack.
    applyStimulus("rstAck", 1, 1, 16'h4444, 0, 0, 16'h0);

`ifdef FETCH_HALT_EN
    applyStimulus("haltAck", 0, 1, HALT_WORD, 0, 0, 16'h0);
    chk("haltAck.haltedConst", {15'd0, o_halted}, 16'h0001);
    applyStimulus("haltConsume", 0, 0, 16'h0, 0, 0, 16'h0);
    applyStimulus("haltJmp", 0, 0, 16'h0, 0, 1, 16'h0300);
    applyStimulus("haltIdle", 0, 1, 16'h0, 0, 0, 16'h0);
    chk("haltIdle.noReq", {15'd0, o_memReq}, 16'h0000);
    applyStimulus("haltRst", 1, 0, 16'h0, 0, 0, 16'h0);
    chk("haltRst.addr", o_memAddr, RESET_PC);
`endif

    // Randomized traffic against the model.
    for (int i = 0; i < 400; i++) begin
      rdata = 16'($urandom_range(0, 16'hFFFE));
      if (HALT_EN && ($urandom_range(0, 29) == 0)) rdata = HALT_WORD;
      applyStimulus("rand", ($urandom_range(0, 49) == 0), ($urandom_range(0, 9) < 4), rdata,
                    ($urandom_range(0, 1) == 1), ($urandom_range(0, 9) == 0),
                    16'($urandom));
    end

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
